ir_transmitter: RTL
===================

// Module: ir_transmitter
// PURPOSE
//  Serialises the four drive-direction bits (Len, Ldir, Ren, Rdir) into a framed IR bit stream
//  for the wired-remote link. It is the controller-side counterpart of the IR receiver.
//  Each frame is: 5-bit preamble 1,0,1,0,0, then 4 payload bits MSB first, then GUARD_BITS idle zeros.
//  The pin driver is active low, so tx_n = ~logical_bit and the idle line sits high.
// PARAMETERS
//  BIT_CYCLES  1  clk cycles each bit is held on tx_n (>=1)
//  GUARD_BITS  4  idle logical-0 bits appended after the payload (>=1)
// PORTS
//  clk      in   1  clock
//  reset    in   1  asynchronous, active-high reset
//  send     in   1  request one frame; sampled when idle or in the last guard cycle
//  repeat   in   1  level: while high, frames are sent back-to-back continuously
//  dirs     in   4  {Len,Ldir,Ren,Rdir}; captured at frame start
//  tx_n     out  1  serial line to IR driver, active low (1 = idle / logical 0)
//  busy     out  1  high while a frame is on the line
//  done     out  1  one-cycle pulse in the cycle after a frame's last guard cycle
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, tx_n=1, busy=0, done=0, shift reg=0, counters=0.
//    Reset mid-frame aborts the frame; no done pulse; the line returns high at once.
//  - All outputs are registered. Frame start is the clk edge at which (send|repeat) is seen in IDLE.
//    At that edge: dirs is latched into a 4-bit payload register; tx_n <= ~1 (first preamble bit); busy <= 1.
//  - FSM: IDLE -> PREAMBLE (5 bits) -> DATA (4 bits, dirs[3] first) -> GUARD (GUARD_BITS bits) -> IDLE.
//    Each bit lasts exactly BIT_CYCLES cycles. Track it with a bit-cycle counter (0..BIT_CYCLES-1)
//    and a bit index per state.
//  - Frame length is (9+GUARD_BITS)*BIT_CYCLES cycles, from the start edge to the end of the last guard cycle.
//  - End of GUARD (last cycle of last guard bit):
//      * done <= 1 for one cycle.
//      * If send|repeat is high: a new frame starts at the same edge with no idle gap.
//        The new dirs is latched, tx_n <= 0, busy stays 1.
//      * Otherwise: state <= IDLE, busy <= 0, tx_n stays 1.
//  - send asserted in any other busy cycle is ignored; it is not queued.
//  - Changes on dirs after frame start do not affect the frame in flight.
//  - send and repeat both high is legal; it behaves as repeat.
//  - In IDLE with no request: tx_n=1, busy=0, done=0.
//  - Counter widths: $clog2 of each range, minimum 1 bit. No wrap outside the defined ranges;
//    counters clear on each state change.
// TESTING
//  1. BIT_CYCLES=1, GUARD_BITS=4, dirs=4'b1010, one-cycle send.
//     -> tx_n from the start edge = 0,1,0,1,1, 0,1,0,1, 1,1,1,1; busy high 13 cycles; done pulses once, then idle.
//  2. BIT_CYCLES=4, dirs=4'b0001, send. -> each level held exactly 4 cycles; frame = 52 cycles;
//     the last payload bit shows tx_n=0 for cycles 33..36.
//  3. Send pulses at cycles 3 and 7 of a busy frame, and dirs toggled mid-frame.
//     -> exactly one frame is sent; its payload equals the dirs latched at start; done pulses once.
//  4. repeat held high for 3 frames, dirs changed during frame 2.
//     -> frames are contiguous with no idle cycle; frame 3 carries the new dirs; done pulses 3 times; busy never drops.
//  5. reset asserted at cycle 6 of a frame. -> tx_n=1, busy=0 immediately; no done;
//     the next send produces a full clean frame.
//  6. Loopback into the IR receiver (BIT_CYCLES=1), dirs swept over all 16 values.
//     -> receiver Len/Ldir/Ren/Rdir match dirs after each frame.

Source files
------------

// File: rtl/ir_transmitter.sv
// Framed IR serialiser: preamble 1,0,1,0,0, four direction bits MSB first, then guard zeros.
// The level request "repeat" is a reserved word in SystemVerilog, so the port is named repeat_en.
module ir_transmitter #(
    parameter int BIT_CYCLES = 1,
    parameter int GUARD_BITS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic       repeat_en,
    input  logic [3:0] dirs,
    output logic       tx_n,
    output logic       busy,
    output logic       done
);

    localparam int CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IMAX = (GUARD_BITS > 5) ? GUARD_BITS : 5;
    localparam int IW   = $clog2(IMAX);

    localparam logic [CW-1:0] CYC_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] PRE_LAST   = IW'(4);
    localparam logic [IW-1:0] DATA_LAST  = IW'(3);
    localparam logic [IW-1:0] GUARD_LAST = IW'(GUARD_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE    = IW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        GUARD
    } state_t;

    state_t        state;
    logic [CW-1:0] cyc;
    logic [IW-1:0] idx;
    logic [3:0]    payload;
    logic          req;
    logic          bit_end;

    assign req     = send | repeat_en;
    assign bit_end = (cyc == CYC_LAST);

    // tx_n is loaded with the level of the *next* bit at each bit boundary,
    // so every output stays registered and frames chain with no gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cyc     <= '0;
            idx     <= '0;
            payload <= '0;
            tx_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cyc <= '0;
                    idx <= '0;
                    if (req) begin
                        state   <= PREAMBLE;
                        payload <= dirs;
                        tx_n    <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        tx_n <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                PREAMBLE: begin
                    if (!bit_end) begin
                        cyc <= cyc + 1'b1;
                    end else begin
                        cyc <= '0;
                        if (idx == PRE_LAST) begin
                            state <= DATA;
                            idx   <= '0;
                            tx_n  <= ~payload[3];
                        end else begin
                            idx  <= idx + 1'b1;
                            // Of preamble bits 1..4 only bit 2 is a logical one.
                            tx_n <= ~(idx == IDX_ONE);
                        end
                    end
                end
                DATA: begin
                    if (!bit_end) begin
                        cyc <= cyc + 1'b1;
                    end else begin
                        cyc <= '0;
                        if (idx == DATA_LAST) begin
                            state <= GUARD;
                            idx   <= '0;
                            tx_n  <= 1'b1;
                        end else begin
                            idx  <= idx + 1'b1;
                            tx_n <= ~payload[2'd2 - idx[1:0]];
                        end
                    end
                end
                GUARD: begin
                    if (!bit_end) begin
                        cyc <= cyc + 1'b1;
                    end else begin
                        cyc <= '0;
                        if (idx == GUARD_LAST) begin
                            done <= 1'b1;
                            idx  <= '0;
                            // A pending request starts the next frame on this same edge.
                            if (req) begin
                                state   <= PREAMBLE;
                                payload <= dirs;
                                tx_n    <= 1'b0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                tx_n  <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cyc   <= '0;
                    idx   <= '0;
                    tx_n  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
